// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder_if
// Description : Bundle of the upstream FIFO pop handshake and the decoded
//               key-event outputs of ps2_scancode_decoder.
//               master = upstream byte source / event consumer,
//               slave  = the decoder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_decoder_if;
  logic       ready;        // upstream FIFO non-empty
  logic [7:0] data;         // upstream FIFO head byte
  logic       nextdata_n;   // active-low pop request
  logic       key_valid;    // one-cycle event strobe
  logic [7:0] key_code;     // set-2 code of the event key
  logic [7:0] key_ascii;    // ASCII of key_code, 0x00 if unmapped
  logic       key_break;    // event is a release
  logic       key_ext;      // event was E0-prefixed
  logic       key_held;     // a key is currently pressed
  logic [7:0] press_count;  // number of emitted make events

  modport master (
    output ready, data,
    input  nextdata_n, key_valid, key_code, key_ascii, key_break, key_ext,
           key_held, press_count
  );

  modport slave (
    input  ready, data,
    output nextdata_n, key_valid, key_code, key_ascii, key_break, key_ext,
           key_held, press_count
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Pops PS/2 set-2 scan-code bytes from an upstream receiver
//               FIFO (one byte per two cycles), folds E0/F0 prefixes into the
//               following key byte and emits one key event per key byte with
//               ASCII translation, held-key tracking and a make counter.
//               Optional feature macro: PS2DEC_REPEAT_FILTER_EN - when defined,
//               typematic repeats of the currently held key are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder (
  input  wire logic               clk,
  input  wire logic               rst,
  ps2_scancode_decoder_if.slave   bus
);

  localparam logic [7:0] c_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] c_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] c_DEV_ERR    = 8'h00;
  localparam logic [7:0] c_DEV_OVR    = 8'hFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    POP  = 1'b1
  } state_t;

  state_t     state_q,       state_d;
  logic [7:0] byte_q,        byte_d;
  logic       nextdata_n_q,  nextdata_n_d;
  logic       key_valid_q,   key_valid_d;
  logic [7:0] key_code_q,    key_code_d;
  logic [7:0] key_ascii_q,   key_ascii_d;
  logic       key_break_q,   key_break_d;
  logic       key_ext_q,     key_ext_d;
  logic       key_held_q,    key_held_d;
  logic [7:0] press_count_q, press_count_d;
  logic       ext_pend_q,    ext_pend_d;
  logic       brk_pend_q,    brk_pend_d;
  logic [7:0] held_code_q,   held_code_d;
  logic       held_ext_q,    held_ext_d;

  logic       is_match;      // captured key equals the held key (code + ext)
  logic       drop_repeat;   // make is a typematic repeat to be suppressed

  // Set-2 to ASCII for the non-extended letter and digit keys only.
  function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Next-state and decode: capture a byte on entry to POP, decode it on exit.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ascii_d   = key_ascii_q;
    key_break_d   = key_break_q;
    key_ext_d     = key_ext_q;
    key_held_d    = key_held_q;
    press_count_d = press_count_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    is_match      = (byte_q == held_code_q) && (ext_pend_q == held_ext_q);
`ifdef PS2DEC_REPEAT_FILTER_EN
    drop_repeat   = !brk_pend_q && key_held_q && is_match;
`else
    drop_repeat   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ready) begin
          state_d      = POP;
          byte_d       = bus.data;
          nextdata_n_d = 1'b0;   // low for exactly the POP cycle
        end
      end
      POP: begin
        state_d = IDLE;
        if (byte_q == c_PREFIX_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == c_PREFIX_BRK) begin
          brk_pend_d = 1'b1;
        end else if ((byte_q == c_DEV_ERR) || (byte_q == c_DEV_OVR)) begin
          // Device error/overrun poisons any partial sequence.
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          if (!drop_repeat) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ascii_d = ext_pend_q ? 8'h00 : set2_to_ascii(byte_q);
            key_break_d = brk_pend_q;
            key_ext_d   = ext_pend_q;
            if (brk_pend_q) begin
              if (is_match) key_held_d = 1'b0;
            end else begin
              key_held_d    = 1'b1;
              held_code_d   = byte_q;
              held_ext_d    = ext_pend_q;
              press_count_d = press_count_q + 8'd1;
            end
          end
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset also aborts a pop in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ascii_q   <= 8'h00;
      key_break_q   <= 1'b0;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      press_count_q <= 8'h00;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ascii_q   <= key_ascii_d;
      key_break_q   <= key_break_d;
      key_ext_q     <= key_ext_d;
      key_held_q    <= key_held_d;
      press_count_q <= press_count_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
    end
  end

  assign bus.nextdata_n  = nextdata_n_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_ascii   = key_ascii_q;
  assign bus.key_break   = key_break_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.key_held    = key_held_q;
  assign bus.press_count = press_count_q;

endmodule
`default_nettype wire
